// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO: default sizes,
// packed status word and the depth legality check.
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 16;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Depth must be a power of two so the pointer wrap bit works, and at least 4.
  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param; master is the
// client side, slave is the FIFO.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic              clr_err;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              almost_full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, clr_err, wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage for sync_fifo_param. Registered read by default;
// asynchronous read when FIFO_FWFT_EN is defined. Storage itself is never reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  assign rdata = mem[raddr];

  logic unused_fwft;
  assign unused_fwft = ^{re, arst_n};
`else
  // Read register holds its word between pops; only it is cleared by reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, sticky error flags and
// synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               arst_n,
  sync_fifo_param_if.slave   bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_T    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_T    = AE_THRESH[ADDR_W:0];

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              full_c;
  logic              empty_c;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_rej;
  logic              rd_rej;
  logic              ovf_q;
  logic              unf_q;
  logic [DATA_W-1:0] mem_rdata;
  fifo_status_t      status;

  // full/empty come from the registered count, so they reflect the cycle start.
  assign full_c  = (count_q == DEPTH_C);
  assign empty_c = (count_q == '0);

  // Flush outranks both requests; requests ignored by a flush are not errors.
  assign wr_acc = bus.wr_en && !full_c  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty_c && !bus.flush;
  assign wr_rej = bus.wr_en &&  full_c  && !bus.flush;
  assign rd_rej = bus.rd_en &&  empty_c && !bus.flush;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error in the same cycle as clr_err wins, so the flag stays set.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !bus.clr_err) || wr_rej;
      unf_q <= (unf_q && !bus.clr_err) || rd_rej;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .arst_n (arst_n),
    .we     (wr_acc),
    .waddr  (wr_ptr[ADDR_W-1:0]),
    .wdata  (bus.wr_data),
    .re     (rd_acc),
    .raddr  (rd_ptr[ADDR_W-1:0]),
    .rdata  (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head entry is presented combinationally; masked to zero while empty.
  assign bus.rd_valid = !empty_c;
  assign bus.rd_data  = empty_c ? '0 : mem_rdata;
`else
  logic vld_p1;

  // ---- read stage boundary: pop request -> registered data/valid ----
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) vld_p1 <= 1'b0;
    else         vld_p1 <= rd_acc;
  end

  assign bus.rd_valid = vld_p1;
  assign bus.rd_data  = mem_rdata;
`endif

  assign status = '{
    full:         full_c,
    almost_full:  (count_q >= AF_T),
    empty:        empty_c,
    almost_empty: (count_q <= AE_T),
    overflow:     ovf_q,
    underflow:    unf_q
  };

  assign bus.full         = status.full;
  assign bus.almost_full  = status.almost_full;
  assign bus.empty        = status.empty;
  assign bus.almost_empty = status.almost_empty;
  assign bus.overflow     = status.overflow;
  assign bus.underflow    = status.underflow;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16).
module tb_sync_fifo_param;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_pass;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    bus.wr_data = '0;
  endtask

  task automatic test_reset();
    idle();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.count !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else n_pass++;
    n_checks++; if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100)
      $display("FAIL reset_flags: got %b want 1100", {bus.empty, bus.almost_empty, bus.full, bus.almost_full}); else n_pass++;
    n_checks++; if ({bus.rd_valid, bus.overflow, bus.underflow} !== 3'b000)
      $display("FAIL reset_vld_err: got %b want 000", {bus.rd_valid, bus.overflow, bus.underflow}); else n_pass++;
    n_checks++; if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data: got %0h want 0", bus.rd_data); else n_pass++;
    arst_n = 1'b1;
    tick();
  endtask

`ifndef FIFO_FWFT_EN
  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      tick();
      n_checks++; if (bus.count !== 5'(i)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i); else n_pass++;
      n_checks++; if ({bus.full, bus.almost_full, bus.almost_empty} !== {i == 16, i >= 14, i <= 2})
        $display("FAIL fill_flags[%0d]: got %b want %b", i, {bus.full, bus.almost_full, bus.almost_empty}, {i == 16, i >= 14, i <= 2});
      else n_pass++;
    end
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL fill_overflow: got %b want 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.count !== 5'd16) $display("FAIL fill_count_hold: got %0d want 16", bus.count); else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      bus.rd_en = 1'b1;
      tick();
      n_checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'(i + 1)})
        $display("FAIL drain_data[%0d]: got vld=%b data=%0h want vld=1 data=%0h", i, bus.rd_valid, bus.rd_data, i + 1); else n_pass++;
      n_checks++; if ({bus.count, bus.empty, bus.almost_empty} !== {5'(15 - i), i == 15, (15 - i) <= 2})
        $display("FAIL drain_state[%0d]: got cnt=%0d e=%b ae=%b", i, bus.count, bus.empty, bus.almost_empty); else n_pass++;
    end
    tick();
    bus.rd_en = 1'b0;
    n_checks++; if ({bus.underflow, bus.rd_valid} !== 2'b10)
      $display("FAIL drain_underflow: got unf=%b vld=%b want unf=1 vld=0", bus.underflow, bus.rd_valid); else n_pass++;
    n_checks++; if (bus.rd_data !== 8'h10) $display("FAIL drain_hold_data: got %0h want 10", bus.rd_data); else n_pass++;
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00)
      $display("FAIL drain_clr_err: got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h20 + i);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'(8'h25 + k);
      tick();
      n_checks++; if (bus.count !== 5'd5) $display("FAIL b2b_count[%0d]: got %0d want 5", k, bus.count); else n_pass++;
      n_checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'(8'h20 + k)})
        $display("FAIL b2b_data[%0d]: got vld=%b data=%0h want %0h", k, bus.rd_valid, bus.rd_data, 8'h20 + k); else n_pass++;
    end
    bus.wr_en = 1'b0;
    n_checks++; if ({bus.overflow, bus.underflow, bus.full, bus.empty} !== 4'b0000)
      $display("FAIL b2b_flags: got %b want 0000", {bus.overflow, bus.underflow, bus.full, bus.empty}); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.rd_data !== 8'(8'h34 + i))
        $display("FAIL b2b_tail[%0d]: got %0h want %0h", i, bus.rd_data, 8'h34 + i); else n_pass++;
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_empty_rw();
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'hAA;
    tick();
    idle();
    n_checks++; if ({bus.underflow, bus.rd_valid, bus.count} !== {2'b10, 5'd1})
      $display("FAIL erw_state: got unf=%b vld=%b cnt=%0d want 1 0 1", bus.underflow, bus.rd_valid, bus.count); else n_pass++;
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    n_checks++; if ({bus.underflow, bus.count} !== {1'b0, 5'd1})
      $display("FAIL erw_clr: got unf=%b cnt=%0d want 0 1", bus.underflow, bus.count); else n_pass++;
    bus.rd_en = 1'b1;
    tick();
    n_checks++; if ({bus.rd_valid, bus.rd_data, bus.empty} !== {1'b1, 8'hAA, 1'b1})
      $display("FAIL erw_read: got vld=%b data=%0h e=%b want 1 aa 1", bus.rd_valid, bus.rd_data, bus.empty); else n_pass++;
    bus.clr_err = 1'b1;
    tick();
    n_checks++; if (bus.underflow !== 1'b1) $display("FAIL erw_clr_vs_set: got %b want 1", bus.underflow); else n_pass++;
    bus.rd_en = 1'b0;
    tick();
    bus.clr_err = 1'b0;
    n_checks++; if (bus.underflow !== 1'b0) $display("FAIL erw_clr_final: got %b want 0", bus.underflow); else n_pass++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
      tick();
    end
    n_checks++; if (bus.count !== 5'd9) $display("FAIL flush_pre_count: got %0d want 9", bus.count); else n_pass++;
    bus.flush = 1'b1; bus.wr_data = 8'h99;
    tick();
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    n_checks++; if ({bus.count, bus.empty, bus.rd_valid} !== {5'd0, 2'b10})
      $display("FAIL flush_state: got cnt=%0d e=%b vld=%b want 0 1 0", bus.count, bus.empty, bus.rd_valid); else n_pass++;
    bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++; if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b1, 8'h77, 5'd0})
      $display("FAIL flush_after: got vld=%b data=%0h cnt=%0d want 1 77 0", bus.rd_valid, bus.rd_data, bus.count); else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h60 + i);
      tick();
    end
    bus.rd_en = 1'b1; bus.wr_data = 8'h63;
    @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    n_checks++; if ({bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== {5'd0, 4'b1100})
      $display("FAIL arst_state: got cnt=%0d flags=%b", bus.count, {bus.empty, bus.almost_empty, bus.full, bus.almost_full}); else n_pass++;
    n_checks++; if ({bus.rd_valid, bus.rd_data, bus.overflow, bus.underflow} !== {1'b0, 8'h00, 2'b00})
      $display("FAIL arst_read: got vld=%b data=%0h err=%b%b", bus.rd_valid, bus.rd_data, bus.overflow, bus.underflow); else n_pass++;
    idle();
    #2 arst_n = 1'b1;
    tick();
    n_checks++; if (bus.count !== 5'd0) $display("FAIL arst_release: got %0d want 0", bus.count); else n_pass++;
  endtask
`else
  task automatic test_fwft();
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    n_checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'h55})
      $display("FAIL fwft_show: got vld=%b data=%0h want 1 55", bus.rd_valid, bus.rd_data); else n_pass++;
    tick();
    n_checks++; if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b1, 8'h55, 5'd1})
      $display("FAIL fwft_hold: got vld=%b data=%0h cnt=%0d", bus.rd_valid, bus.rd_data, bus.count); else n_pass++;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++; if ({bus.empty, bus.rd_valid} !== 2'b10)
      $display("FAIL fwft_pop: got e=%b vld=%b want 1 0", bus.empty, bus.rd_valid); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'hC0 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    n_checks++; if (bus.rd_data !== 8'hC0) $display("FAIL fwft_head0: got %0h want c0", bus.rd_data); else n_pass++;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++; if ({bus.rd_data, bus.count} !== {8'hC1, 5'd1})
      $display("FAIL fwft_head1: got %0h cnt=%0d want c1 1", bus.rd_data, bus.count); else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    arst_n   = 1'b0;
    test_reset();
`ifndef FIFO_FWFT_EN
    test_fill();
    test_drain();
    test_back_to_back();
    test_empty_rw();
    test_flush();
    test_async_reset();
`else
    test_fwft();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
